// File: rtl/sipo_frame_rx_if.sv
// Parallel word handshake between the serial frame receiver and its downstream consumer.
interface sipo_frame_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             parity_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    output data_ready
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver: start bit, WIDTH data bits MSB first, optional
// even parity, then a single-entry holding register behind a valid/ready handshake.
module sipo_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  sipo_frame_rx_if.master   bus,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             perr_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             frame_done;
  logic             word_err;
  logic             accept;
  logic             load;

  always_comb begin
    shifted    = {shreg_q[WIDTH-2:0], serial_in};
    last_bit   = (cnt_q == CW'(WIDTH - 1));
    frame_done = 1'b0;
    word       = shifted;
    word_err   = 1'b0;
    case (state_q)
      StData: begin
        if (last_bit && !PARITY_EN) frame_done = 1'b1;
      end
      StParity: begin
        frame_done = 1'b1;
        word       = shreg_q;
        word_err   = (^shreg_q) ^ serial_in;
      end
      default: ;
    endcase
    accept = valid_q & bus.data_ready;
    // Holding register is free if empty or being drained on this very edge.
    load   = frame_done & (~valid_q | accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (serial_in) begin
            state_q <= StData;
            cnt_q   <= '0;
          end
        end
        StData: begin
          shreg_q <= shifted;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) state_q <= PARITY_EN ? StParity : StIdle;
        end
        StParity: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      if (load) begin
        data_q  <= word;
        perr_q  <= word_err;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (frame_done && !load) overrun_q <= 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: an 8-bit parity instance and a 4-bit no-parity instance.
module tb_sipo_frame_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic si8 = 1'b0;
  logic si4 = 1'b0;
  logic ovr8, busy8, ovr4, busy4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_frame_rx_if #(.WIDTH(8)) bus8 ();
  sipo_frame_rx_if #(.WIDTH(4)) bus4 ();

  sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .serial_in (si8),
    .bus       (bus8),
    .overrun   (ovr8),
    .busy      (busy8)
  );

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1'b0)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .serial_in (si4),
    .bus       (bus4),
    .overrun   (ovr4),
    .busy      (busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits MSB first, parity bit: exactly 10 edges.
  task automatic send8(input logic [7:0] w, input logic p);
    si8 = 1'b1;
    tick();
    for (int i = 7; i >= 0; i--) begin
      si8 = w[i];
      tick();
    end
    si8 = p;
    tick();
    si8 = 1'b0;
  endtask

  initial begin
    bus8.data_ready = 1'b0;
    bus4.data_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(bus8.data_valid), 32'h0);
    check("rst_data", 32'(bus8.data_out), 32'h0);
    check("rst_perr", 32'(bus8.parity_err), 32'h0);
    check("rst_ovr", 32'(ovr8), 32'h0);
    check("rst_busy", 32'(busy8), 32'h0);

    // Frame 0xA5, good parity, check latency edge by edge.
    si8 = 1'b1;
    tick();
    check("start_busy", 32'(busy8), 32'h1);
    for (int i = 7; i >= 0; i--) begin
      si8 = 8'hA5 >> i;
      tick();
    end
    check("pre_par_valid", 32'(bus8.data_valid), 32'h0);
    check("pre_par_busy", 32'(busy8), 32'h1);
    si8 = 1'b0;
    tick();
    check("a5_valid", 32'(bus8.data_valid), 32'h1);
    check("a5_data", 32'(bus8.data_out), 32'hA5);
    check("a5_perr", 32'(bus8.parity_err), 32'h0);
    check("a5_busy", 32'(busy8), 32'h0);
    tick();
    check("a5_hold", 32'(bus8.data_out), 32'hA5);
    bus8.data_ready = 1'b1;
    tick();
    check("a5_drain", 32'(bus8.data_valid), 32'h0);
    bus8.data_ready = 1'b0;

    // Same word with bad parity bit.
    send8(8'hA5, 1'b1);
    check("bad_valid", 32'(bus8.data_valid), 32'h1);
    check("bad_data", 32'(bus8.data_out), 32'hA5);
    check("bad_perr", 32'(bus8.parity_err), 32'h1);
    bus8.data_ready = 1'b1;
    tick();
    check("bad_drain", 32'(bus8.data_valid), 32'h0);

    // Back-to-back with data_ready held high.
    send8(8'hA5, 1'b0);
    check("b2b1_valid", 32'(bus8.data_valid), 32'h1);
    check("b2b1_data", 32'(bus8.data_out), 32'hA5);
    send8(8'h3C, 1'b0);
    check("b2b2_valid", 32'(bus8.data_valid), 32'h1);
    check("b2b2_data", 32'(bus8.data_out), 32'h3C);
    check("b2b_ovr", 32'(ovr8), 32'h0);
    tick();
    check("b2b2_pulse", 32'(bus8.data_valid), 32'h0);
    bus8.data_ready = 1'b0;

    // Back-to-back with no consumer: second frame is dropped.
    send8(8'h81, 1'b0);
    send8(8'h7E, 1'b0);
    check("ovr_valid", 32'(bus8.data_valid), 32'h1);
    check("ovr_data", 32'(bus8.data_out), 32'h81);
    check("ovr_perr", 32'(bus8.parity_err), 32'h0);
    check("ovr_flag", 32'(ovr8), 32'h1);
    tick();
    check("ovr_sticky", 32'(ovr8), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovr_clear", 32'(ovr8), 32'h0);
    check("ovr_rst_valid", 32'(bus8.data_valid), 32'h0);

    // Abort mid-frame: reset during data bit 4 with the line high.
    si8 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    si8 = 1'b0;
    check("abort_busy", 32'(busy8), 32'h0);
    check("abort_data", 32'(bus8.data_out), 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_novalid", 32'(bus8.data_valid), 32'h0);
    check("abort_idle", 32'(busy8), 32'h0);
    send8(8'hFF, 1'b0);
    check("ff_valid", 32'(bus8.data_valid), 32'h1);
    check("ff_data", 32'(bus8.data_out), 32'hFF);
    check("ff_perr", 32'(bus8.parity_err), 32'h0);

    // WIDTH=4, no parity: start + 1,1,0,1.
    si4 = 1'b1;
    tick();
    si4 = 1'b1;
    tick();
    si4 = 1'b1;
    tick();
    si4 = 1'b0;
    tick();
    check("w4_pre_valid", 32'(bus4.data_valid), 32'h0);
    si4 = 1'b1;
    tick();
    si4 = 1'b0;
    check("w4_valid", 32'(bus4.data_valid), 32'h1);
    check("w4_data", 32'(bus4.data_out), 32'hD);
    check("w4_perr", 32'(bus4.parity_err), 32'h0);
    check("w4_busy", 32'(busy4), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
